// File: rtl/if_id_stage_if.sv
// Fetch-stage bundle between if_id_stage (slave) and its driver (master).
// Counter signals exist only when IF_PERF_CNT_EN is defined.
interface if_id_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] target_pc;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output stall, flush, target_pc, instr_in,
    input  pc_out, id_pc, id_instr, id_valid, stall_cnt, flush_cnt
  );
  modport slave (
    input  stall, flush, target_pc, instr_in,
    output pc_out, id_pc, id_instr, id_valid, stall_cnt, flush_cnt
  );
`else
  modport master (
    output stall, flush, target_pc, instr_in,
    input  pc_out, id_pc, id_instr, id_valid
  );
  modport slave (
    input  stall, flush, target_pc, instr_in,
    output pc_out, id_pc, id_instr, id_valid
  );
`endif
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage: program counter plus IF/ID pipeline register with stall/flush control.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          XLEN      = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  if_id_stage_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_instr;
  logic            r_id_valid;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_target_aligned;

  assign w_pc_next        = r_pc + 32'd4;
  assign w_target_aligned = bus.target_pc & ~32'h1;

  // Flush outranks stall so a redirect is never lost behind a load-use hazard.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_id_pc    <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (bus.flush) begin
      r_pc       <= w_target_aligned;
      r_id_pc    <= '0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc       <= w_pc_next;
      r_id_pc    <= r_pc;
      r_id_instr <= bus.instr_in;
      r_id_valid <= 1'b1;
    end
  end

  assign bus.pc_out   = r_pc;
  assign bus.id_pc    = r_id_pc;
  assign bus.id_instr = r_id_instr;
  assign bus.id_valid = r_id_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // A stall cycle that coincides with a flush is counted only as a flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.flush) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end else if (bus.stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; instruction memory returns 32'hC0DE_0000 ^ addr.
// Counter checks are compiled in only when IF_PERF_CNT_EN is defined.
module tb_if_id_stage;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  if_id_stage_if bus ();

  if_id_stage dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // Combinational instruction memory keyed on the fetch address
  assign bus.instr_in = 32'hC0DE_0000 ^ bus.pc_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.target_pc = 32'h0;
    step(); step();
    checkCount++; if (bus.pc_out !== 32'h0) $display("[TB] FAIL rst_pc: got %h want %h", bus.pc_out, 32'h0); else passCount++;
    checkCount++; if (bus.id_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", bus.id_valid); else passCount++;
    checkCount++; if (bus.id_instr !== 32'h13) $display("[TB] FAIL rst_instr: got %h want %h", bus.id_instr, 32'h13); else passCount++;
    checkCount++; if (bus.id_pc !== 32'h0) $display("[TB] FAIL rst_idpc: got %h want %h", bus.id_pc, 32'h0); else passCount++;
  endtask

  task automatic test_advance();
    reset = 1'b0;
    step();
    checkCount++; if (bus.id_valid !== 1'b1) $display("[TB] FAIL adv1_valid: got %b want 1", bus.id_valid); else passCount++;
    checkCount++; if (bus.id_pc !== 32'h0) $display("[TB] FAIL adv1_idpc: got %h want %h", bus.id_pc, 32'h0); else passCount++;
    checkCount++; if (bus.id_instr !== 32'hC0DE_0000) $display("[TB] FAIL adv1_instr: got %h want %h", bus.id_instr, 32'hC0DE_0000); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h4) $display("[TB] FAIL adv1_pc: got %h want %h", bus.pc_out, 32'h4); else passCount++;
    step();
    checkCount++; if (bus.id_pc !== 32'h4) $display("[TB] FAIL adv2_idpc: got %h want %h", bus.id_pc, 32'h4); else passCount++;
    checkCount++; if (bus.id_instr !== 32'hC0DE_0004) $display("[TB] FAIL adv2_instr: got %h want %h", bus.id_instr, 32'hC0DE_0004); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h8) $display("[TB] FAIL adv2_pc: got %h want %h", bus.pc_out, 32'h8); else passCount++;
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checkCount++; if (bus.pc_out !== 32'h8) $display("[TB] FAIL stall_pc[%0d]: got %h want %h", i, bus.pc_out, 32'h8); else passCount++;
      checkCount++; if (bus.id_pc !== 32'h4) $display("[TB] FAIL stall_idpc[%0d]: got %h want %h", i, bus.id_pc, 32'h4); else passCount++;
      checkCount++; if (bus.id_instr !== 32'hC0DE_0004) $display("[TB] FAIL stall_instr[%0d]: got %h want %h", i, bus.id_instr, 32'hC0DE_0004); else passCount++;
      checkCount++; if (bus.id_valid !== 1'b1) $display("[TB] FAIL stall_valid[%0d]: got %b want 1", i, bus.id_valid); else passCount++;
    end
`ifdef IF_PERF_CNT_EN
    checkCount++; if (bus.stall_cnt !== 32'd2) $display("[TB] FAIL stall_cnt: got %0d want 2", bus.stall_cnt); else passCount++;
`endif
    bus.stall = 1'b0;
    step();
    checkCount++; if (bus.id_pc !== 32'h8) $display("[TB] FAIL resume_idpc: got %h want %h", bus.id_pc, 32'h8); else passCount++;
    checkCount++; if (bus.id_instr !== 32'hC0DE_0008) $display("[TB] FAIL resume_instr: got %h want %h", bus.id_instr, 32'hC0DE_0008); else passCount++;
    checkCount++; if (bus.pc_out !== 32'hC) $display("[TB] FAIL resume_pc: got %h want %h", bus.pc_out, 32'hC); else passCount++;
  endtask

  task automatic test_flush_over_stall();
    bus.flush = 1'b1; bus.stall = 1'b1; bus.target_pc = 32'h100;
    step();
    checkCount++; if (bus.pc_out !== 32'h100) $display("[TB] FAIL fl_pc: got %h want %h", bus.pc_out, 32'h100); else passCount++;
    checkCount++; if (bus.id_instr !== 32'h13) $display("[TB] FAIL fl_instr: got %h want %h", bus.id_instr, 32'h13); else passCount++;
    checkCount++; if (bus.id_valid !== 1'b0) $display("[TB] FAIL fl_valid: got %b want 0", bus.id_valid); else passCount++;
    checkCount++; if (bus.id_pc !== 32'h0) $display("[TB] FAIL fl_idpc: got %h want %h", bus.id_pc, 32'h0); else passCount++;
`ifdef IF_PERF_CNT_EN
    checkCount++; if (bus.flush_cnt !== 32'd1) $display("[TB] FAIL fl_cnt: got %0d want 1", bus.flush_cnt); else passCount++;
    checkCount++; if (bus.stall_cnt !== 32'd2) $display("[TB] FAIL fl_stallcnt: got %0d want 2", bus.stall_cnt); else passCount++;
`endif
    bus.flush = 1'b0; bus.stall = 1'b0;
    step();
    checkCount++; if (bus.id_pc !== 32'h100) $display("[TB] FAIL fl2_idpc: got %h want %h", bus.id_pc, 32'h100); else passCount++;
    checkCount++; if (bus.id_instr !== 32'hC0DE_0100) $display("[TB] FAIL fl2_instr: got %h want %h", bus.id_instr, 32'hC0DE_0100); else passCount++;
    checkCount++; if (bus.id_valid !== 1'b1) $display("[TB] FAIL fl2_valid: got %b want 1", bus.id_valid); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h104) $display("[TB] FAIL fl2_pc: got %h want %h", bus.pc_out, 32'h104); else passCount++;
  endtask

  task automatic test_align();
    bus.flush = 1'b1; bus.target_pc = 32'h203;
    step();
    checkCount++; if (bus.pc_out !== 32'h202) $display("[TB] FAIL align_pc: got %h want %h", bus.pc_out, 32'h202); else passCount++;
    bus.flush = 1'b0;
    step();
    checkCount++; if (bus.id_pc !== 32'h202) $display("[TB] FAIL align_idpc: got %h want %h", bus.id_pc, 32'h202); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h206) $display("[TB] FAIL align_next: got %h want %h", bus.pc_out, 32'h206); else passCount++;
  endtask

  task automatic test_wrap();
    bus.flush = 1'b1; bus.target_pc = 32'hFFFF_FFFC;
    step();
    checkCount++; if (bus.pc_out !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pc0: got %h want %h", bus.pc_out, 32'hFFFF_FFFC); else passCount++;
    bus.flush = 1'b0;
    step();
    checkCount++; if (bus.id_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_idpc: got %h want %h", bus.id_pc, 32'hFFFF_FFFC); else passCount++;
    checkCount++; if (bus.id_instr !== 32'h3F21_FFFC) $display("[TB] FAIL wrap_instr: got %h want %h", bus.id_instr, 32'h3F21_FFFC); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h0) $display("[TB] FAIL wrap_pc1: got %h want %h", bus.pc_out, 32'h0); else passCount++;
    step();
    checkCount++; if (bus.id_pc !== 32'h0) $display("[TB] FAIL wrap_idpc2: got %h want %h", bus.id_pc, 32'h0); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h4) $display("[TB] FAIL wrap_pc2: got %h want %h", bus.pc_out, 32'h4); else passCount++;
`ifdef IF_PERF_CNT_EN
    checkCount++; if (bus.flush_cnt !== 32'd3) $display("[TB] FAIL wrap_flcnt: got %0d want 3", bus.flush_cnt); else passCount++;
`endif
  endtask

  task automatic test_reset_in_stall();
    bus.stall = 1'b1;
    step();
    checkCount++; if (bus.pc_out !== 32'h4) $display("[TB] FAIL rs_hold: got %h want %h", bus.pc_out, 32'h4); else passCount++;
`ifdef IF_PERF_CNT_EN
    checkCount++; if (bus.stall_cnt !== 32'd3) $display("[TB] FAIL rs_stcnt: got %0d want 3", bus.stall_cnt); else passCount++;
`endif
    reset = 1'b1;
    step();
    checkCount++; if (bus.pc_out !== 32'h0) $display("[TB] FAIL rs_pc: got %h want %h", bus.pc_out, 32'h0); else passCount++;
    checkCount++; if (bus.id_valid !== 1'b0) $display("[TB] FAIL rs_valid: got %b want 0", bus.id_valid); else passCount++;
    checkCount++; if (bus.id_instr !== 32'h13) $display("[TB] FAIL rs_instr: got %h want %h", bus.id_instr, 32'h13); else passCount++;
`ifdef IF_PERF_CNT_EN
    checkCount++; if (bus.stall_cnt !== 32'd0) $display("[TB] FAIL rs_stcnt0: got %0d want 0", bus.stall_cnt); else passCount++;
    checkCount++; if (bus.flush_cnt !== 32'd0) $display("[TB] FAIL rs_flcnt0: got %0d want 0", bus.flush_cnt); else passCount++;
`endif
    bus.stall = 1'b0; bus.flush = 1'b1; bus.target_pc = 32'h300;
    step();
    checkCount++; if (bus.pc_out !== 32'h0) $display("[TB] FAIL rf_pc: got %h want %h", bus.pc_out, 32'h0); else passCount++;
    reset = 1'b0; bus.flush = 1'b0;
    step();
    checkCount++; if (bus.id_valid !== 1'b1) $display("[TB] FAIL rel_valid: got %b want 1", bus.id_valid); else passCount++;
    checkCount++; if (bus.id_pc !== 32'h0) $display("[TB] FAIL rel_idpc: got %h want %h", bus.id_pc, 32'h0); else passCount++;
    checkCount++; if (bus.pc_out !== 32'h4) $display("[TB] FAIL rel_pc: got %h want %h", bus.pc_out, 32'h4); else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_advance();
    test_stall();
    test_flush_over_stall();
    test_align();
    test_wrap();
    test_reset_in_stall();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
